// File: rtl/ddfs_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// ddfs_sweep_ctrl
//
// Builds the fcontrol word for the ddfs phase accumulator as a stepped
// frequency sweep. The sweep starts at f_start and moves toward f_stop in
// f_step increments. Each frequency is held for dwell+1 clocks. The block can
// run a single sweep or a continuous triangle (up/down) sweep. fcontrol is
// registered and drives the ddfs fcontrol input directly on the same clock.
//
// Ports
//   clk_i       system clock; all logic runs on the rising edge
//   rst_i       synchronous, active-high reset
//   start_i     one-cycle pulse; latches the sweep parameters and starts a
//               sweep (ignored while busy)
//   stop_i      aborts the sweep; returns to idle and holds fcontrol
//   mode_i      0 = single sweep, 1 = continuous triangle (sampled live)
//   f_start_i   first frequency word (sampled when start is accepted)
//   f_stop_i    end frequency word; may be below f_start
//   f_step_i    unsigned step magnitude
//   dwell_i     extra hold cycles per frequency
//   fcontrol_o  frequency control word to the ddfs (registered)
//   busy_o      high while sweeping
//   done_o      one-cycle pulse when a single sweep completes
// ----------------------------------------------------------------------------
module ddfs_sweep_ctrl #(
    parameter int FW = 23,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          mode_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_step_i,
    input  logic [DW-1:0] dwell_i,
    output logic [FW-1:0] fcontrol_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fctl_q, fctl_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Sweep parameters latched on an accepted start.
    logic [FW-1:0] fstart_q, fstart_d;
    logic [FW-1:0] fstop_q, fstop_d;
    logic [FW-1:0] fstep_q, fstep_d;
    logic [DW-1:0] dwell_q, dwell_d;
    // Set when f_stop >= f_start. f_stop is then the upper endpoint.
    logic          stop_hi_q, stop_hi_d;

    logic [FW-1:0] hi_w, lo_w;
    logic          degen_w;
    logic          stop_end_w;

    // Step up by stp. Any overshoot past hi, including a carry out of FW
    // bits, clamps to hi, so the word never wraps.
    function automatic logic [FW-1:0] step_up(input logic [FW-1:0] x,
                                              input logic [FW-1:0] stp,
                                              input logic [FW-1:0] hi);
        logic [FW:0] sum;
        sum = {1'b0, x} + {1'b0, stp};
        if (sum[FW] || (sum[FW-1:0] > hi))
            return hi;
        return sum[FW-1:0];
    endfunction

    // Step down by stp. Any undershoot below lo, including a borrow, clamps
    // to lo.
    function automatic logic [FW-1:0] step_down(input logic [FW-1:0] x,
                                                input logic [FW-1:0] stp,
                                                input logic [FW-1:0] lo);
        logic [FW:0] diff;
        diff = {1'b0, x} - {1'b0, stp};
        if (diff[FW] || (diff[FW-1:0] < lo))
            return lo;
        return diff[FW-1:0];
    endfunction

    assign hi_w    = stop_hi_q ? fstop_q : fstart_q;
    assign lo_w    = stop_hi_q ? fstart_q : fstop_q;
    // A zero step or a zero-span sweep can never progress. Such a sweep ends
    // after the first dwell.
    assign degen_w = (fstep_q == '0) || (fstart_q == fstop_q);
    // True when the endpoint of the current leg is f_stop rather than f_start.
    assign stop_end_w = (state_q == UP) ? stop_hi_q : !stop_hi_q;

    always_comb begin
        state_d   = state_q;
        fctl_d    = fctl_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        fstart_d  = fstart_q;
        fstop_d   = fstop_q;
        fstep_d   = fstep_q;
        dwell_d   = dwell_q;
        stop_hi_d = stop_hi_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // stop takes priority over start in the same cycle.
                if (start_i && !stop_i) begin
                    fstart_d  = f_start_i;
                    fstop_d   = f_stop_i;
                    fstep_d   = f_step_i;
                    dwell_d   = dwell_i;
                    stop_hi_d = (f_stop_i >= f_start_i);
                    fctl_d    = f_start_i;
                    cnt_d     = dwell_i;
                    busy_d    = 1'b1;
                    state_d   = (f_stop_i >= f_start_i) ? UP : DOWN;
                end
            end

            UP, DOWN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (degen_w) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (fctl_q != ((state_q == UP) ? hi_w : lo_w)) begin
                    fctl_d = (state_q == UP) ? step_up(fctl_q, fstep_q, hi_w)
                                             : step_down(fctl_q, fstep_q, lo_w);
                    cnt_d  = dwell_q;
                end else if (!mode_i && stop_end_w) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Turn around and take the first step of the new leg in
                    // this cycle, so the endpoint is held only once. With
                    // mode=0 this completes the return leg toward f_stop.
                    if (state_q == UP) begin
                        state_d = DOWN;
                        fctl_d  = step_down(fctl_q, fstep_q, lo_w);
                    end else begin
                        state_d = UP;
                        fctl_d  = step_up(fctl_q, fstep_q, hi_w);
                    end
                    cnt_d = dwell_q;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            fctl_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            fstart_q  <= '0;
            fstop_q   <= '0;
            fstep_q   <= '0;
            dwell_q   <= '0;
            stop_hi_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fctl_q    <= fctl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            fstart_q  <= fstart_d;
            fstop_q   <= fstop_d;
            fstep_q   <= fstep_d;
            dwell_q   <= dwell_d;
            stop_hi_q <= stop_hi_d;
        end
    end

    assign fcontrol_o = fctl_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
